// File: rtl/x64_adc_sched_pkg.sv
// Shared types and helpers for the x64 ADC stream scheduler.
package x64_adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sched_state_e;

  localparam int unsigned DEFAULT_SLOT_CYCLES = 4;
  localparam int unsigned ADC_WORD_W          = 24;

  // Wraps an index that is at most 2*n-1 back into 0..n-1.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/x64_adc_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward, ptr moves past the winner on advance.
module x64_adc_rr_arbiter
  import x64_adc_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    logic [IDX_W-1:0] pos;
    logic             found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'(rr_wrap(32'(ptr) + k, NUM_REQ));
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IDX_W'(rr_wrap(32'(idx) + 32'd1, NUM_REQ));
    end
  end

endmodule

// File: rtl/x64_adc_stream_sched.sv
// Shares the 4:1 stream serializer between NUM_REQ group producers, one load per slot.
// Optional gap statistics counter enabled by defining X64_ADC_SCHED_STATS_EN.
module x64_adc_stream_sched
  import x64_adc_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 4 * ADC_WORD_W,
  parameter int unsigned SLOT_CYCLES = DEFAULT_SLOT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           mux_din,
  output logic                        mux_dinvld,
  output logic [$clog2(NUM_REQ)-1:0]  mux_tag,
  output logic                        busy,
  output logic [15:0]                 gap_cnt
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FIRST = (SLOT_CYCLES > 1) ? CNT_W'(1) : '0;

  sched_state_e       state;
  sched_state_e       state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               eligible;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               granted;

  // A slot boundary in RUN with enable still high is the only grant opportunity.
  assign eligible = (state == RUN) && enable && (cnt == '0);
  assign arb_req  = eligible ? req_valid : '0;
  assign granted  = |grant;

  x64_adc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (granted),
    .grant   (grant),
    .idx     (grant_idx)
  );

  assign req_ready = grant;
  assign busy      = (state != IDLE) || (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = (cnt == '0) ? IDLE : STOP;
      STOP:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot counter: starts at 1 on a grant, wraps to 0 after SLOT_CYCLES-1, parks at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (granted) begin
      cnt <= CNT_FIRST;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_din    <= '0;
      mux_tag    <= '0;
      mux_dinvld <= 1'b0;
    end else begin
      mux_dinvld <= granted;
      if (granted) begin
        mux_din <= req_data[32'(grant_idx) * DATA_W +: DATA_W];
        mux_tag <= grant_idx;
      end
    end
  end

`ifdef X64_ADC_SCHED_STATS_EN
  // Counts slot boundaries that were offered but found nobody pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (eligible && (req_valid == '0) && (gap_cnt != 16'hFFFF)) begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end
`else
  assign gap_cnt = 16'h0000;
`endif

endmodule
